// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp : data-memory responder for the MEM-stage load/store interface.
//
// Takes one word-aligned load or store at a time. After WAIT_CYC wait states
// it returns a single-cycle response carrying the load data or an error flag.
// busy stalls the pipeline while an access is outstanding.
//
// Ports
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   req_valid    : MEM stage presents a load/store
//   req_we       : 1 = store, 0 = load
//   req_addr     : byte address
//   req_wdata    : store data
//   req_ready    : responder is idle and can accept this cycle
//   resp_valid   : one-cycle completion pulse
//   resp_rdata   : load data (0 for stores and errors), valid with resp_valid
//   resp_err     : misaligned or out-of-range access, valid with resp_valid
//   busy         : stall request to the hazard unit
// ---------------------------------------------------------------------------
module dmem_resp #(
   parameter int ADDR_W   = 9,
   parameter int DEPTH    = 128,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int IDX_W  = ADDR_W - 2;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [31:0]         lat_wdata;
   logic [31:0]         mem [DEPTH];

   logic                accept;
   logic                enter_resp;
   logic                c_we;
   logic [ADDR_W-1:0]   c_addr;
   logic [31:0]         c_wdata;
   logic [IDX_W-1:0]    c_idx;
   logic [MEM_AW-1:0]   c_row;
   logic                c_err;

   assign accept     = req_valid && (state == S_IDLE);
   assign enter_resp = (state_nxt == S_RESP);

   // With zero wait states the access commits on the accept edge itself, so
   // the commit must use the live request rather than the latched copy.
   always_comb begin
      c_we    = lat_we;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      if (state == S_IDLE) begin
         c_we    = req_we;
         c_addr  = req_addr;
         c_wdata = req_wdata;
      end
   end

   assign c_idx = c_addr[ADDR_W-1:2];
   assign c_row = c_idx[MEM_AW-1:0];
   assign c_err = (c_addr[1:0] != 2'b00) || (32'(c_idx) >= DEPTH);

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req_valid) state_nxt = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
         S_WAIT: if (cnt == CNT_W'(1)) state_nxt = S_RESP;
         S_RESP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      req_ready = (state == S_IDLE);
      busy      = ((state == S_IDLE) && req_valid) || (state == S_WAIT);
   end

   // Wait counter and request latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         if (accept) begin
            cnt       <= CNT_W'(WAIT_CYC);
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
         end else if (state == S_WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Response registers: only non-zero during the RESP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= enter_resp;
         resp_err   <= enter_resp && c_err;
         resp_rdata <= (enter_resp && !c_err && !c_we) ? mem[c_row] : '0;
      end
   end

   // Storage; reset clears every word, and a reset mid-access drops the store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (enter_resp && c_we && !c_err) begin
         mem[c_row] <= c_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_dmem_resp : self-checking bench for dmem_resp.
// Instance a: WAIT_CYC=2, DEPTH=64.  Instance b: WAIT_CYC=0, DEPTH=128.
// The reference model is a plain word array per instance plus the latency
// rule "response on edge WAIT_CYC+1, counting the accept edge as edge 1".
// ---------------------------------------------------------------------------
module tb_dmem_resp;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;

   logic        a_valid, a_we, a_ready, a_rvalid, a_err, a_busy;
   logic [8:0]  a_addr;
   logic [31:0] a_wdata, a_rdata;
   logic        b_valid, b_we, b_ready, b_rvalid, b_err, b_busy;
   logic [8:0]  b_addr;
   logic [31:0] b_wdata, b_rdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mm [2][128];
   int          last_acc = 0;
   bit          last_keep = 0;
   int          last_sel = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_resp #(.ADDR_W(9), .DEPTH(64), .WAIT_CYC(2)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
      .req_ready(a_ready), .resp_valid(a_rvalid), .resp_rdata(a_rdata),
      .resp_err(a_err), .busy(a_busy));

   dmem_resp #(.ADDR_W(9), .DEPTH(128), .WAIT_CYC(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
      .req_ready(b_ready), .resp_valid(b_rvalid), .resp_rdata(b_rdata),
      .resp_err(b_err), .busy(b_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic we,
                        input logic [8:0] addr, input logic [31:0] wd);
      if (sel == 0) begin
         a_valid = v; a_we = we; a_addr = addr; a_wdata = wd;
      end else begin
         b_valid = v; b_we = we; b_addr = addr; b_wdata = wd;
      end
   endtask

   task automatic sample(input int sel, output logic rdy, output logic rv,
                         output logic [31:0] rd, output logic er, output logic bz);
      if (sel == 0) begin
         rdy = a_ready; rv = a_rvalid; rd = a_rdata; er = a_err; bz = a_busy;
      end else begin
         rdy = b_ready; rv = b_rvalid; rd = b_rdata; er = b_err; bz = b_busy;
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 128; i++) mm[s][i] = 32'h0;
   endtask

   // One full access; returns at the negedge of the response cycle.
   // keep=1 leaves req_valid high so the next call is back-to-back.
   task automatic acc(input int sel, input logic we, input logic [8:0] addr,
                      input logic [31:0] wd, input bit keep);
      int          w, depth, idx;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic        rdy, rv, er, bz;
      logic [31:0] rd;
      w      = (sel == 0) ? 2 : 0;
      depth  = (sel == 0) ? 64 : 128;
      idx    = int'(addr >> 2);
      exp_err = (addr[1:0] != 2'b00) || (idx >= depth);
      exp_rd  = (!exp_err && !we) ? mm[sel][idx] : 32'h0;

      @(posedge clk); #1;
      drive(sel, 1'b1, we, addr, wd);
      @(negedge clk);
      sample(sel, rdy, rv, rd, er, bz);
      chk("ready_idle", rdy, 1);
      chk("busy_req", bz, 1);
      chk("rvalid_idle", rv, 0);
      if (last_keep && last_sel == sel) chk("b2b_spacing", cyc - last_acc, w + 2);
      last_acc = cyc;
      for (int k = 1; k <= w + 1; k++) begin
         @(negedge clk);
         sample(sel, rdy, rv, rd, er, bz);
         chk("rvalid", rv, (k == w + 1) ? 1 : 0);
         chk("busy", bz, (k <= w) ? 1 : 0);
         chk("ready_busy", rdy, 0);
         chk("err", er, (k == w + 1) ? exp_err : 1'b0);
         if (k == w + 1) chk("rdata", rd, exp_rd);
      end
      if (!exp_err && we) mm[sel][idx] = wd;
      if (!keep) drive(sel, 1'b0, 1'b0, 9'h0, 32'h0);
      last_keep = keep;
      last_sel  = sel;
   endtask

   initial begin
      logic        rdy, rv, er, bz;
      logic [31:0] rd;
      logic [8:0]  ra;
      int          sel;

      clear_model();
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
      #12;
      for (int s = 0; s < 2; s++) begin
         sample(s, rdy, rv, rd, er, bz);
         chk("rst_rvalid", rv, 0);
         chk("rst_rdata", rd, 0);
         chk("rst_err", er, 0);
         chk("rst_ready", rdy, 1);
         chk("rst_busy", bz, 0);
      end
      rst_n = 1'b1;

      // Directed: WAIT_CYC=2 / DEPTH=64 instance
      acc(0, 1'b0, 9'h010, 32'h0, 0);
      acc(0, 1'b1, 9'h024, 32'hDEADBEEF, 0);
      acc(0, 1'b0, 9'h024, 32'h0, 0);
      acc(0, 1'b0, 9'h028, 32'h0, 0);
      acc(0, 1'b1, 9'h026, 32'h12345678, 0);
      acc(0, 1'b0, 9'h024, 32'h0, 0);
      acc(0, 1'b0, 9'h100, 32'h0, 0);
      acc(0, 1'b1, 9'h1FC, 32'hCAFEF00D, 0);
      acc(0, 1'b0, 9'h0FC, 32'h0, 0);
      acc(0, 1'b0, 9'h023, 32'h0, 0);

      @(negedge clk);
      sample(0, rdy, rv, rd, er, bz);
      chk("idle_busy", bz, 0);
      chk("idle_ready", rdy, 1);

      // Directed: WAIT_CYC=0 back-to-back with req_valid held
      acc(1, 1'b1, 9'h004, 32'hA5A5A5A5, 1);
      acc(1, 1'b0, 9'h004, 32'h0, 1);
      acc(1, 1'b1, 9'h1FC, 32'h0BADCAFE, 1);
      acc(1, 1'b0, 9'h1FC, 32'h0, 1);
      acc(1, 1'b0, 9'h1FD, 32'h0, 0);

      // Reset while a store sits in WAIT
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 9'h030, 32'h55AA55AA);
      @(posedge clk); #3;
      drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
      rst_n = 1'b0;
      #1;
      sample(0, rdy, rv, rd, er, bz);
      chk("arst_rvalid", rv, 0);
      chk("arst_rdata", rd, 0);
      chk("arst_err", er, 0);
      chk("arst_ready", rdy, 1);
      chk("arst_busy", bz, 0);
      clear_model();
      #10;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         sample(0, rdy, rv, rd, er, bz);
         chk("no_resp_aborted", rv, 0);
      end
      acc(0, 1'b0, 9'h030, 32'h0, 0);
      acc(0, 1'b0, 9'h024, 32'h0, 0);
      acc(1, 1'b0, 9'h004, 32'h0, 0);

      // Randomized traffic against the word-array model
      for (int i = 0; i < 80; i++) begin
         sel = int'($urandom_range(0, 1));
         ra  = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) ra = {7'($urandom_range(0, 79)), 2'b00};
         if ($urandom_range(0, 1) != 0) ra[8:2] = 7'($urandom_range(0, 7));
         acc(sel, 1'($urandom_range(0, 1)), ra, $urandom, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
